// File: rtl/i2s_ring_fifo.sv
// i2s_ring_fifo: circular-buffer sample FIFO between the I2S receiver and the
// downstream audio consumer. One sample is pushed per rising edge of the
// receiver's sample-ready level; the oldest sample is presented
// first-word-fall-through on fifo_out.
//
// Ports:
//   CLK              system clock, all logic on the rising edge
//   RST              synchronous active-high reset
//   i2s_sample_ready sample-ready level from the receiver (already in CLK domain)
//   fifo_in          sample data, valid the first cycle i2s_sample_ready is high
//   pop              consume the head entry this cycle
//   clr_flags        clear the sticky overflow/underflow flags
//   fifo_out         head entry, valid while fifo_empty=0
//   fifo_empty       count==0
//   fifo_full        count==DEPTH
//   fifo_count       entries held, 0..DEPTH
//   overflow         sticky: a push met a full FIFO
//   underflow        sticky: pop asserted while empty
//
// Build option:
//   I2S_FIFO_OVERWRITE_EN  when defined, a push into a full FIFO (no pop)
//                          overwrites the oldest entry instead of being dropped.
module i2s_ring_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i2s_sample_ready,
  input  logic [WIDTH-1:0] fifo_in,
  input  logic             pop,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] fifo_out,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [AW:0]      fifo_count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic             prev_ready_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic push, empty, full, wr_en, rd_adv, ovf_evt, unf_evt;

  always_comb begin
    push    = i2s_sample_ready & ~prev_ready_q;
    empty   = (count_q == '0);
    full    = (count_q == FullCount);
    // A pop in the same cycle frees a slot, so only push-without-pop overflows.
    ovf_evt = push & full & ~pop;
    unf_evt = pop & empty;
`ifdef I2S_FIFO_OVERWRITE_EN
    // Overwrite mode: the write always lands, and the oldest entry is retired.
    wr_en   = push;
    rd_adv  = (pop & ~empty) | ovf_evt;
`else
    wr_en   = push & ~ovf_evt;
    rd_adv  = pop & ~empty;
`endif
    wr_ptr_d = wr_en  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_adv ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !rd_adv) begin
      count_d = count_q + (AW+1)'(1);
    end else if (rd_adv && !wr_en) begin
      count_d = count_q - (AW+1)'(1);
    end

    // A new error event in the same cycle as clr_flags wins.
    overflow_d  = (overflow_q  & ~clr_flags) | ovf_evt;
    underflow_d = (underflow_q & ~clr_flags) | unf_evt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // Held at 1 so a level already high at reset release does not push.
      prev_ready_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      prev_ready_q <= i2s_sample_ready;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= fifo_in;
    end
  end

  assign fifo_out   = mem_q[rd_ptr_q];
  assign fifo_empty = empty;
  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_i2s_ring_fifo.sv
// Scoreboard bench for i2s_ring_fifo: a DEPTH=16 and a DEPTH=4 instance share
// the same stimulus; a queue-based reference model predicts status and the
// data each accepted pop must return.
module tb_i2s_ring_fifo;

  logic        CLK;
  logic        RST;
  logic        rdy;
  logic [31:0] din;
  logic        pop;
  logic        clr;

  logic [31:0] out16, out4;
  logic        empty16, empty4, full16, full4;
  logic [4:0]  cnt16;
  logic [2:0]  cnt4;
  logic        ovf16, ovf4, unf16, unf4;

  i2s_ring_fifo #(.WIDTH(32), .DEPTH(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .i2s_sample_ready(rdy), .fifo_in(din), .pop(pop),
    .clr_flags(clr), .fifo_out(out16), .fifo_empty(empty16), .fifo_full(full16),
    .fifo_count(cnt16), .overflow(ovf16), .underflow(unf16)
  );

  i2s_ring_fifo #(.WIDTH(32), .DEPTH(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .i2s_sample_ready(rdy), .fifo_in(din), .pop(pop),
    .clr_flags(clr), .fifo_out(out4), .fifo_empty(empty4), .fifo_full(full4),
    .fifo_count(cnt4), .overflow(ovf4), .underflow(unf4)
  );

  logic [31:0] dout  [2];
  logic [31:0] dcnt  [2];
  logic        dempty[2];
  logic        dfull [2];
  logic        dovf  [2];
  logic        dunf  [2];

  assign dout[0] = out16;        assign dout[1] = out4;
  assign dcnt[0] = 32'(cnt16);   assign dcnt[1] = 32'(cnt4);
  assign dempty[0] = empty16;    assign dempty[1] = empty4;
  assign dfull[0] = full16;      assign dfull[1] = full4;
  assign dovf[0] = ovf16;        assign dovf[1] = ovf4;
  assign dunf[0] = unf16;        assign dunf[1] = unf4;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int          depth [2] = '{16, 4};
  logic [31:0] mq    [2][$];
  logic [31:0] sb    [2][$];
  bit          m_prev[2];
  bit          m_ovf [2];
  bit          m_unf [2];
  bit          m_zero[2];

  task automatic cmp(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    bit          push, empty, full, ovf_evt, unf_evt;
    logic [31:0] junk;
    if (RST) begin
      mq[k].delete();
      m_prev[k] = 1'b1;
      m_ovf[k]  = 1'b0;
      m_unf[k]  = 1'b0;
      m_zero[k] = 1'b1;
      return;
    end
    push    = rdy && !m_prev[k];
    empty   = (mq[k].size() == 0);
    full    = (mq[k].size() == depth[k]);
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (pop) begin
      if (empty) unf_evt = 1'b1;
      else sb[k].push_back(mq[k].pop_front());
    end
    if (push) begin
      if (full && !pop) begin
        ovf_evt = 1'b1;
`ifdef I2S_FIFO_OVERWRITE_EN
        junk = mq[k].pop_front();
        mq[k].push_back(din);
        m_zero[k] = 1'b0;
`endif
      end else begin
        mq[k].push_back(din);
        m_zero[k] = 1'b0;
      end
    end
    m_ovf[k]  = (m_ovf[k] && !clr) || ovf_evt;
    m_unf[k]  = (m_unf[k] && !clr) || unf_evt;
    m_prev[k] = rdy;
  endtask

  task automatic check_inst(input int k);
    cmp("count", k, dcnt[k], mq[k].size());
    cmp("empty", k, 32'(dempty[k]), 32'(mq[k].size() == 0));
    cmp("full", k, 32'(dfull[k]), 32'(mq[k].size() == depth[k]));
    cmp("overflow", k, 32'(dovf[k]), 32'(m_ovf[k]));
    cmp("underflow", k, 32'(dunf[k]), 32'(m_unf[k]));
    if (mq[k].size() != 0) cmp("head", k, dout[k], mq[k][0]);
    else if (m_zero[k]) cmp("head_reset", k, dout[k], 32'h0);
  endtask

  // Drive one cycle: inputs settle, model predicts, edge, then check status.
  task automatic step(input bit r, input bit rd, input logic [31:0] d, input bit p,
                      input bit c);
    RST = r; rdy = rd; din = d; pop = p; clr = c;
    model_step(0);
    model_step(1);
    @(posedge CLK);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic push_word(input logic [31:0] d);
    step(0, 1, d, 0, 0);
    step(0, 0, 32'hDEAD_BEEF, 0, 0);
  endtask

  // Monitor: on every accepted pop the DUT head must match the scoreboard.
  always @(negedge CLK) begin
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      if (!RST && pop && !dempty[k]) begin
        if (sb[k].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected inst=%0d actual=%0h required=no_pop", k, dout[k]);
        end else begin
          e = sb[k].pop_front();
          cmp("pop_data", k, dout[k], e);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; rdy = 1'b1; din = '0; pop = 1'b0; clr = 1'b0;

    // Reset with ready held high; no push after release.
    step(1, 1, 32'h1111_1111, 0, 0);
    step(1, 1, 32'h1111_1111, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h2222_2222, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'hA5A5_0001, 0, 0);
    step(0, 0, 0, 1, 0);

    // Level held high 5 cycles: exactly one push of the first-cycle data.
    for (int i = 0; i < 5; i++) step(0, 1, 32'h3000_0000 + 32'(i), 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
    push_word(32'h110);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);

    // Full, push and pop together, then drain.
    for (int i = 0; i < 16; i++) push_word(32'h180 + 32'(i));
    step(0, 1, 32'h200, 1, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0);

    // Empty: pop alone, clear, then push+pop together.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'h0BAD_F00D, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);

    // Wrap-around: 40 interleaved push/pop pairs.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, $urandom, 0, 0);
      step(0, 0, 0, 1, 0);
      cmp("wrap_count_le2", 1, 32'(dcnt[1] <= 2), 32'd1);
    end

    // Mid-stream reset.
    for (int i = 0; i < 3; i++) push_word($urandom);
    step(1, 1, $urandom, 1, 0);
    cmp("midrst_count", 0, dcnt[0], 32'd0);
    cmp("midrst_empty", 0, 32'(dempty[0]), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) cmp("sb_drained", k, sb[k].size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_ring_fifo.md
# i2s_ring_fifo

Parametrised circular-buffer sample FIFO between the I2S receiver and the downstream audio consumer (DSP or bus bridge). Pushes one sample on each rising edge of the receiver's sample-ready level and presents the oldest sample first-word-fall-through. Generalises the earlier fixed-size shift FIFO:
- configurable width and depth;
- true full/empty/count status;
- simultaneous push and pop;
- sticky overflow and underflow error flags.

## Interface
- WIDTH, 32, bits per sample word
- DEPTH, 16, number of entries; power of two, minimum 2
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- i2s_sample_ready  input  1  level from I2S receiver, already synchronous to CLK; each low→high transition is one new sample
- fifo_in  input  WIDTH  sample data, valid in the cycle i2s_sample_ready first reads high
- pop  input  1  consume the head entry this cycle
- clr_flags  input  1  clears overflow and underflow
- fifo_out  output  WIDTH  head entry; valid while fifo_empty=0
- fifo_empty  output  1  count==0
- fifo_full  output  1  count==DEPTH
- fifo_count  output  AW+1  entries held, range 0..DEPTH
- overflow  output  1  sticky: a push met a full FIFO
- underflow  output  1  sticky: pop asserted while empty

## Operation
- Edge detect:
  - prev_ready register holds last-cycle i2s_sample_ready.
  - push = i2s_sample_ready & ~prev_ready.
  - A held-high level yields exactly one push.
- Storage: DEPTH×WIDTH register array, write pointer wr_ptr and read pointer rd_ptr (AW bits each), plus count register. Pointers wrap DEPTH-1 → 0 naturally.
- Push, not full: mem[wr_ptr] ← fifo_in; wr_ptr+1.
- Pop, not empty: rd_ptr+1.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Push and pop together:
  - Empty: push accepted, pop ignored, underflow set, count→1.
  - Full: both accepted, count stays DEPTH, overflow not set.
  - Otherwise: both accepted.
- Push while full, no pop: data dropped, pointers and count unchanged, overflow ← 1 (behaviour changes under the macro; see Configuration).
- Pop while empty: no state change, underflow ← 1.
- clr_flags clears both flags. If a new error event occurs in the same cycle, the flag is set (the set wins).
- fifo_out = mem[rd_ptr], combinational from the array.

## Timing
- Reset (RST=1 at a clock edge):
  - wr_ptr, rd_ptr, count, overflow, underflow ← 0.
  - All mem entries ← 0.
  - prev_ready ← 1, so a level already high at reset release does not push.
  - Outputs after reset: fifo_out=0, fifo_empty=1, fifo_full=0, fifo_count=0, flags 0.
- Reset asserted mid-operation discards all contents the next edge. Push/pop in that cycle are ignored.
- Push latency: i2s_sample_ready rises at edge n; write occurs at edge n.
  - fifo_empty falls after edge n.
  - fifo_out shows the sample in cycle n+1.
- Pop latency: pop sampled at edge n. The next entry appears on fifo_out after edge n, zero extra cycles.
- Status outputs are registered-derived: fifo_empty, fifo_full and fifo_count are decoded from count, with no combinational path from pop/push.
- Minimum push spacing is 2 cycles (high, then low).

## Configuration
- I2S_FIFO_OVERWRITE_EN
  - Defined: push while full (no pop) overwrites the oldest entry. mem[wr_ptr] ← fifo_in, wr_ptr+1, rd_ptr+1, count stays DEPTH, overflow ← 1. Newest DEPTH samples are retained.
  - Undefined (default): push while full is dropped as described in Operation. Oldest DEPTH samples are retained.

## Test plan
- Reset with i2s_sample_ready held high → no push after release; fifo_empty=1, fifo_count=0, fifo_out=0. Then drop and raise ready with fifo_in=32'hA5A5_0001 → count=1 next cycle, fifo_out=A5A5_0001.
- Hold i2s_sample_ready high for 5 cycles with fifo_in changing every cycle → exactly one push; stored value is the first-cycle data.
- DEPTH=16:
  - Push 0x100..0x10F → fifo_full=1.
  - Push 0x110 → overflow=1.
  - Pop 16 times → outputs 0x100..0x10F in order (default build).
  - With I2S_FIFO_OVERWRITE_EN, the same sequence outputs 0x101..0x110.
- Full FIFO, push 0x200 and pop in the same cycle → count stays 16, overflow stays 0, head advances. The last pop of the drain returns 0x200.
- Empty FIFO:
  - pop alone → underflow=1, count=0.
  - Assert clr_flags → underflow=0.
  - Push and pop in the same cycle → count=1, underflow=1.
- Wrap-around: 40 interleaved push/pop pairs at DEPTH=4 keep count ≤2. Data order is preserved across pointer wrap. Mid-stream RST → count=0, fifo_empty=1 the next cycle.
